// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI flash read sequencer: FSM states,
// spi_host status/control bit positions and the READ command byte mux.
`timescale 1ns/1ps
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        POLL,
        ACT,
        WAITIDLE,
        DESEL,
        DONE
    } state_t;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         CMD_BYTES    = 4;

    // spi_host STATUS register bit positions, plus the sequencer's own busy bit
    localparam int ST_RXE     = 0;
    localparam int ST_RXF     = 1;
    localparam int ST_TXE     = 2;
    localparam int ST_TXF     = 3;
    localparam int ST_BUSY    = 4;
    localparam int ST_SEQBUSY = 5;

    // spi_host CONTROL register: {2'b00, speed[2:0], target[2:0]}
    localparam int CTRL_TGT_LSB = 0;
    localparam int CTRL_SPD_LSB = 3;

    function automatic logic [7:0] ctrl_word(input logic [2:0] speed, input logic [2:0] target);
        logic [7:0] w;
        w = '0;
        w[CTRL_SPD_LSB +: 3] = speed;
        w[CTRL_TGT_LSB +: 3] = target;
        return w;
    endfunction

    // Byte to transmit given how many bytes have already been enqueued.
    function automatic logic [7:0] cmd_byte(input logic [2:0] pos, input logic [23:0] addr);
        case (pos)
            3'd0:    return SPI_CMD_READ;
            3'd1:    return addr[23:16];
            3'd2:    return addr[15:8];
            3'd3:    return addr[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_read_seq.sv
// Sequencer that drives spi_host through its register port to perform a flash
// READ (0x03) and streams the returned bytes out on a valid/ready port.
`timescale 1ns/1ps
module spi_flash_read_seq
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       cpu_d_i,
    output logic [7:0]       cpu_d_o,
    input  logic             cpu_wr_i,
    input  logic             cpu_rd_i,
    input  logic             cpu_ad_i,
    output logic [7:0]       host_d_o,
    input  logic [7:0]       host_d_i,
    output logic             host_wr_o,
    output logic             host_rd_o,
    output logic             host_ad_o,
    input  logic             start_i,
    input  logic [23:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [2:0]       target_i,
    input  logic [2:0]       speed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i
);

    localparam int                 OUTST_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(FIFO_DEPTH);
    localparam logic [LEN_W:0]     CMD_CNT   = (LEN_W+1)'(CMD_BYTES);

    state_t             state, state_next;
    logic [23:0]        addr_r;
    logic [2:0]         target_r, speed_r;
    logic [LEN_W:0]     tx_left, rx_left, tx_left_next, rx_left_next;
    logic [2:0]         disc, tx_pos;
    logic [OUTST_W-1:0] outst;
    logic [4:0]         stat_r;
    logic               do_rx, do_tx;

    assign tx_left_next = tx_left - {{LEN_W{1'b0}}, do_tx};
    assign rx_left_next = rx_left - {{LEN_W{1'b0}}, do_rx};
    assign busy_o       = (state != IDLE) && (state != DONE);
    assign done_o       = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (start_i) state_next = SELECT;
            SELECT:   state_next = POLL;
            POLL:     state_next = ACT;
            ACT:      state_next = (tx_left_next == '0 && rx_left_next == '0) ? WAITIDLE : POLL;
            WAITIDLE: if (!host_d_i[ST_BUSY]) state_next = DESEL;
            DESEL:    state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        host_d_o  = '0;
        host_wr_o = 1'b0;
        host_rd_o = 1'b0;
        host_ad_o = 1'b0;
        cpu_d_o   = cpu_ad_i ? 8'h00 : 8'(1 << ST_SEQBUSY);
        // RX has priority; a held output byte blocks dequeue unless it is a discard
        do_rx = (state == ACT) && !stat_r[ST_RXE] && (disc != '0 || !rd_valid_o || rd_ready_i);
        do_tx = (state == ACT) && !do_rx && !stat_r[ST_TXF] && (tx_left != '0) && (outst < OUTST_MAX);
        unique case (state)
            IDLE: begin
                host_d_o  = cpu_d_i;
                host_wr_o = cpu_wr_i;
                host_rd_o = cpu_rd_i;
                host_ad_o = cpu_ad_i;
                cpu_d_o   = host_d_i;
            end
            SELECT: begin
                host_wr_o = 1'b1;
                host_d_o  = ctrl_word(speed_r, target_r);
            end
            ACT: begin
                host_ad_o = do_rx || do_tx;
                host_rd_o = do_rx;
                host_wr_o = do_tx;
                if (do_tx) host_d_o = cmd_byte(tx_pos, addr_r);
            end
            DESEL: begin
                host_wr_o = 1'b1;
                host_d_o  = ctrl_word(speed_r, 3'b000);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r   <= '0;
            target_r <= '0;
            speed_r  <= '0;
            tx_left  <= '0;
            rx_left  <= '0;
            disc     <= '0;
            tx_pos   <= '0;
            outst    <= '0;
            stat_r   <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                addr_r   <= addr_i;
                target_r <= target_i;
                speed_r  <= speed_i;
                tx_left  <= {1'b0, len_i} + CMD_CNT;
                rx_left  <= {1'b0, len_i} + CMD_CNT;
                disc     <= 3'(CMD_BYTES);
                tx_pos   <= '0;
                outst    <= '0;
            end
            if (state == POLL) stat_r <= host_d_i[4:0];
            if (do_rx) begin
                rx_left <= rx_left_next;
                outst   <= outst - 1'b1;
                if (disc != '0) disc <= disc - 1'b1;
            end
            if (do_tx) begin
                tx_left <= tx_left_next;
                outst   <= outst + 1'b1;
                if (tx_pos != 3'(CMD_BYTES)) tx_pos <= tx_pos + 1'b1;
            end
        end
    end

    // Output byte register; clearing is state-independent so a final byte can outlive DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else if (do_rx && disc == '0) begin
            rd_data_o  <= host_d_i;
            rd_valid_o <= 1'b1;
        end else if (rd_valid_o && rd_ready_i) begin
            rd_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq with a behavioural spi_host and a flash
// that returns (address[7:0] ^ 0xA5) for every data byte.
`timescale 1ns/1ps
module tb_spi_flash_read_seq;

    logic        clk, reset;
    logic [7:0]  cpu_d_i, cpu_d_o, host_d_o, host_d_i, rd_data_o;
    logic        cpu_wr_i, cpu_rd_i, cpu_ad_i, host_wr_o, host_rd_o, host_ad_o;
    logic        start_i, busy_o, done_o, rd_valid_o, rd_ready_i;
    logic [23:0] addr_i;
    logic [15:0] len_i;
    logic [2:0]  target_i, speed_i;

    int n_cmp = 0;
    int n_bad = 0;

    spi_flash_read_seq dut (
        .clk(clk), .reset(reset),
        .cpu_d_i(cpu_d_i), .cpu_d_o(cpu_d_o), .cpu_wr_i(cpu_wr_i), .cpu_rd_i(cpu_rd_i), .cpu_ad_i(cpu_ad_i),
        .host_d_o(host_d_o), .host_d_i(host_d_i), .host_wr_o(host_wr_o), .host_rd_o(host_rd_o), .host_ad_o(host_ad_o),
        .start_i(start_i), .addr_i(addr_i), .len_i(len_i), .target_i(target_i), .speed_i(speed_i),
        .busy_o(busy_o), .done_o(done_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- spi_host + flash model ----------------
    logic [7:0]  txm [16];
    logic [7:0]  rxm [16];
    logic [3:0]  tx_wp, tx_rp, rx_wp, rx_rp;
    int          tx_cnt, rx_cnt, sh_cnt, fpos, tc_v, rc_v;
    logic        cs_active, shifting;
    logic [7:0]  sh_byte, miso_v;
    logic [23:0] faddr;
    int          tx_ovf = 0, rx_ovf = 0, rx_unf = 0;
    logic [7:0]  mosi_log[$], ctrl_log[$], got[$];
    logic [7:0]  status;

    always_comb begin
        status = {3'b000, (shifting || tx_cnt != 0), (tx_cnt == 16), (tx_cnt == 0), (rx_cnt == 16), (rx_cnt == 0)};
        host_d_i = host_ad_o ? rxm[rx_rp] : status;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
            tx_cnt <= 0; rx_cnt <= 0; sh_cnt <= 0; fpos <= 0;
            cs_active <= 1'b0; shifting <= 1'b0; sh_byte <= '0; faddr <= '0;
        end else if (host_wr_o && !host_ad_o) begin
            ctrl_log.push_back(host_d_o);
            if (host_d_o[2:0] == 3'b000) begin
                tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
                tx_cnt <= 0; rx_cnt <= 0; shifting <= 1'b0; cs_active <= 1'b0;
            end else begin
                cs_active <= 1'b1;
                fpos <= 0;
            end
        end else begin
            tc_v = tx_cnt;
            rc_v = rx_cnt;
            if (host_wr_o && host_ad_o) begin
                if (tc_v < 16) begin txm[tx_wp] <= host_d_o; tx_wp <= tx_wp + 1'b1; tc_v++; end
                else tx_ovf++;
            end
            if (host_rd_o && host_ad_o) begin
                if (rc_v > 0) begin rx_rp <= rx_rp + 1'b1; rc_v--; end
                else rx_unf++;
            end
            if (shifting) begin
                if (sh_cnt > 1) sh_cnt <= sh_cnt - 1;
                else begin
                    shifting <= 1'b0;
                    mosi_log.push_back(sh_byte);
                    case (fpos)
                        1: faddr[23:16] <= sh_byte;
                        2: faddr[15:8]  <= sh_byte;
                        3: faddr[7:0]   <= sh_byte;
                        default: ;
                    endcase
                    miso_v = (fpos < 4) ? 8'hFF : (8'(faddr + 24'(fpos - 4)) ^ 8'hA5);
                    fpos <= fpos + 1;
                    if (rc_v < 16) begin rxm[rx_wp] <= miso_v; rx_wp <= rx_wp + 1'b1; rc_v++; end
                    else rx_ovf++;
                end
            end else if (cs_active && tx_cnt > 0) begin
                sh_byte <= txm[tx_rp];
                tx_rp <= tx_rp + 1'b1;
                tc_v--;
                shifting <= 1'b1;
                sh_cnt <= 8;
            end
            tx_cnt <= tc_v;
            rx_cnt <= rc_v;
        end
    end

    // ---------------- monitors (sampled on the falling edge) ----------------
    int done_cnt = 0, valid_seen = 0, peak = 0;
    always @(negedge clk) begin
        if (rd_valid_o) valid_seen++;
        if (rd_valid_o && rd_ready_i) got.push_back(rd_data_o);
        if (done_o) done_cnt++;
        if (tx_cnt + rx_cnt + int'(shifting) > peak) peak = tx_cnt + rx_cnt + int'(shifting);
    end

    function automatic logic [7:0] qbyte(input logic [7:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 8'hEE;
    endfunction

    task automatic start_seq(input logic [23:0] a, input logic [15:0] l, input logic [2:0] t, input logic [2:0] s);
        @(posedge clk); #1;
        addr_i = a; len_i = l; target_i = t; speed_i = s; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done_o) begin timed_out = 1'b0; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_cmp++; if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rd_valid_o); end
        n_cmp++; if (host_wr_o !== 1'b0)  begin n_bad++; $display("FAIL reset_host_wr: got %b want 0", host_wr_o); end
        n_cmp++; if (host_rd_o !== 1'b0)  begin n_bad++; $display("FAIL reset_host_rd: got %b want 0", host_rd_o); end
        n_cmp++; if (rd_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data_o); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1;
        cpu_ad_i = 1'b0; cpu_d_i = 8'h28; cpu_wr_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (host_wr_o !== 1'b1) begin n_bad++; $display("FAIL pass_wr: got %b want 1", host_wr_o); end
        n_cmp++; if (host_ad_o !== 1'b0) begin n_bad++; $display("FAIL pass_ad: got %b want 0", host_ad_o); end
        n_cmp++; if (host_d_o !== 8'h28) begin n_bad++; $display("FAIL pass_data: got %h want 28", host_d_o); end
        @(posedge clk); #1;
        cpu_wr_i = 1'b0; cpu_rd_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (host_rd_o !== 1'b1) begin n_bad++; $display("FAIL pass_rd: got %b want 1", host_rd_o); end
        n_cmp++; if (cpu_d_o !== 8'h05)  begin n_bad++; $display("FAIL pass_status: got %h want 05", cpu_d_o); end
        @(posedge clk); #1;
        cpu_rd_i = 1'b0;
    endtask

    task automatic test_read_len3();
        int m0 = mosi_log.size(), g0 = got.size(), c0 = ctrl_log.size(), d0 = done_cnt;
        logic [7:0] exp_m[7] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_g[3] = '{8'hE0, 8'hE3, 8'hE2};
        bit to;
        start_seq(24'h012345, 16'd3, 3'd1, 3'd3);
        wait_done(2000, to);
        n_cmp++; if (to !== 1'b0)     begin n_bad++; $display("FAIL len3_timeout: done seen=%b want 1", !to); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL len3_busy_at_done: got %b want 0", busy_o); end
        repeat (20) @(negedge clk);
        n_cmp++; if (mosi_log.size() - m0 != 7) begin n_bad++; $display("FAIL len3_mosi_count: got %0d want 7", mosi_log.size() - m0); end
        for (int i = 0; i < 7; i++) begin
            n_cmp++; if (qbyte(mosi_log, m0 + i) !== exp_m[i]) begin n_bad++; $display("FAIL len3_mosi[%0d]: got %h want %h", i, qbyte(mosi_log, m0 + i), exp_m[i]); end
        end
        n_cmp++; if (got.size() - g0 != 3) begin n_bad++; $display("FAIL len3_rd_count: got %0d want 3", got.size() - g0); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (qbyte(got, g0 + i) !== exp_g[i]) begin n_bad++; $display("FAIL len3_rd[%0d]: got %h want %h", i, qbyte(got, g0 + i), exp_g[i]); end
        end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL len3_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (qbyte(ctrl_log, c0) !== 8'h19)     begin n_bad++; $display("FAIL len3_ctrl_sel: got %h want 19", qbyte(ctrl_log, c0)); end
        n_cmp++; if (qbyte(ctrl_log, c0 + 1) !== 8'h18) begin n_bad++; $display("FAIL len3_ctrl_desel: got %h want 18", qbyte(ctrl_log, c0 + 1)); end
    endtask

    task automatic test_len0();
        int m0 = mosi_log.size(), v0 = valid_seen, d0 = done_cnt;
        logic [7:0] exp_m[4] = '{8'h03, 8'hAB, 8'hCD, 8'hEF};
        bit to;
        start_seq(24'hABCDEF, 16'd0, 3'd1, 3'd0);
        wait_done(2000, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL len0_timeout: done seen=%b want 1", !to); end
        repeat (10) @(negedge clk);
        n_cmp++; if (mosi_log.size() - m0 != 4) begin n_bad++; $display("FAIL len0_mosi_count: got %0d want 4", mosi_log.size() - m0); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (qbyte(mosi_log, m0 + i) !== exp_m[i]) begin n_bad++; $display("FAIL len0_mosi[%0d]: got %h want %h", i, qbyte(mosi_log, m0 + i), exp_m[i]); end
        end
        n_cmp++; if (valid_seen - v0 != 0) begin n_bad++; $display("FAIL len0_valid_cycles: got %0d want 0", valid_seen - v0); end
        n_cmp++; if (done_cnt - d0 != 1)   begin n_bad++; $display("FAIL len0_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (cs_active !== 1'b0)   begin n_bad++; $display("FAIL len0_cs_released: cs_active=%b want 0", cs_active); end
    endtask

    task automatic test_backpressure();
        int g0 = got.size(), c0 = ctrl_log.size();
        bit to, reached;
        start_seq(24'h000100, 16'd64, 3'd2, 3'd7);
        reached = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (got.size() - g0 >= 10) begin reached = 1'b1; break; end
        end
        n_cmp++; if (reached !== 1'b1) begin n_bad++; $display("FAIL bp_stream_start: reached=%b want 1", reached); end
        @(posedge clk); #1;
        rd_ready_i = 1'b0;
        repeat (500) @(posedge clk);
        #1 rd_ready_i = 1'b1;
        wait_done(5000, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: done seen=%b want 1", !to); end
        repeat (20) @(negedge clk);
        n_cmp++; if (got.size() - g0 != 64) begin n_bad++; $display("FAIL bp_rd_count: got %0d want 64", got.size() - g0); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++; if (qbyte(got, g0 + i) !== (8'(i) ^ 8'hA5)) begin n_bad++; $display("FAIL bp_rd[%0d]: got %h want %h", i, qbyte(got, g0 + i), 8'(i) ^ 8'hA5); end
        end
        n_cmp++; if (peak != 16)  begin n_bad++; $display("FAIL bp_outstanding_peak: got %0d want 16", peak); end
        n_cmp++; if (rx_ovf != 0) begin n_bad++; $display("FAIL bp_rx_overflow: got %0d want 0", rx_ovf); end
        n_cmp++; if (tx_ovf != 0) begin n_bad++; $display("FAIL bp_tx_overflow: got %0d want 0", tx_ovf); end
        n_cmp++; if (rx_unf != 0) begin n_bad++; $display("FAIL bp_rx_underflow: got %0d want 0", rx_unf); end
        n_cmp++; if (qbyte(ctrl_log, c0) !== 8'h3A) begin n_bad++; $display("FAIL bp_ctrl_sel: got %h want 3a", qbyte(ctrl_log, c0)); end
    endtask

    task automatic test_cpu_blocked();
        int m0 = mosi_log.size(), c0 = ctrl_log.size();
        int fwd = 0;
        bit to;
        start_seq(24'h000200, 16'd8, 3'd3, 3'd2);
        repeat (2) @(posedge clk);
        #1 cpu_ad_i = 1'b0; cpu_d_i = 8'h1A; cpu_wr_i = 1'b1;
        repeat (20) begin @(negedge clk); if (host_wr_o && host_d_o == cpu_d_i) fwd++; end
        @(posedge clk); #1 cpu_ad_i = 1'b1; cpu_d_i = 8'hAA;
        repeat (20) begin @(negedge clk); if (host_wr_o && host_d_o == cpu_d_i) fwd++; end
        @(posedge clk); #1 cpu_wr_i = 1'b0; cpu_rd_i = 1'b1; cpu_ad_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b1)   begin n_bad++; $display("FAIL cpu_busy: got %b want 1", busy_o); end
        n_cmp++; if (cpu_d_o !== 8'h20) begin n_bad++; $display("FAIL cpu_status_busy: got %h want 20", cpu_d_o); end
        @(posedge clk); #1 cpu_ad_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (cpu_d_o !== 8'h00) begin n_bad++; $display("FAIL cpu_data_busy: got %h want 00", cpu_d_o); end
        @(posedge clk); #1 cpu_rd_i = 1'b0; cpu_ad_i = 1'b0;
        wait_done(3000, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL cpu_timeout: done seen=%b want 1", !to); end
        repeat (10) @(negedge clk);
        n_cmp++; if (fwd != 0) begin n_bad++; $display("FAIL cpu_forwarded_writes: got %0d want 0", fwd); end
        n_cmp++; if (ctrl_log.size() - c0 != 2) begin n_bad++; $display("FAIL cpu_ctrl_count: got %0d want 2", ctrl_log.size() - c0); end
        n_cmp++; if (qbyte(ctrl_log, c0 + 1) !== 8'h10) begin n_bad++; $display("FAIL cpu_ctrl_desel: got %h want 10", qbyte(ctrl_log, c0 + 1)); end
        n_cmp++; if (mosi_log.size() - m0 != 12) begin n_bad++; $display("FAIL cpu_mosi_count: got %0d want 12", mosi_log.size() - m0); end
        for (int i = 0; i < 12; i++) begin
            logic [7:0] e;
            e = (i == 0) ? 8'h03 : (i == 2) ? 8'h02 : 8'h00;
            n_cmp++; if (qbyte(mosi_log, m0 + i) !== e) begin n_bad++; $display("FAIL cpu_mosi[%0d]: got %h want %h", i, qbyte(mosi_log, m0 + i), e); end
        end
    endtask

    task automatic test_start_ignored();
        int m0 = mosi_log.size(), g0 = got.size(), d0 = done_cnt;
        bit to;
        start_seq(24'h000400, 16'd4, 3'd7, 3'd1);
        repeat (10) @(posedge clk);
        #1 addr_i = 24'hFFFFFF; len_i = 16'd1; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        wait_done(3000, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL restart_timeout: done seen=%b want 1", !to); end
        repeat (300) @(negedge clk);
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL restart_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (busy_o !== 1'b0)    begin n_bad++; $display("FAIL restart_busy: got %b want 0", busy_o); end
        n_cmp++; if (mosi_log.size() - m0 != 8) begin n_bad++; $display("FAIL restart_mosi_count: got %0d want 8", mosi_log.size() - m0); end
        n_cmp++; if (qbyte(mosi_log, m0 + 2) !== 8'h04) begin n_bad++; $display("FAIL restart_addr_mid: got %h want 04", qbyte(mosi_log, m0 + 2)); end
        n_cmp++; if (got.size() - g0 != 4) begin n_bad++; $display("FAIL restart_rd_count: got %0d want 4", got.size() - g0); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (qbyte(got, g0 + i) !== (8'(i) ^ 8'hA5)) begin n_bad++; $display("FAIL restart_rd[%0d]: got %h want %h", i, qbyte(got, g0 + i), 8'(i) ^ 8'hA5); end
        end
    endtask

    task automatic test_reset_mid();
        int m0, g0, c0, d0;
        bit to, hit;
        logic [7:0] exp_m[6] = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
        rd_ready_i = 1'b0;
        start_seq(24'h000300, 16'd20, 3'd1, 3'd1);
        hit = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rd_valid_o && host_wr_o && host_ad_o) begin hit = 1'b1; break; end
        end
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_act: reached=%b want 1", hit); end
        reset = 1'b1;
        #1;
        n_cmp++; if (busy_o !== 1'b0)     begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        n_cmp++; if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", rd_valid_o); end
        n_cmp++; if (done_o !== 1'b0)     begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done_o); end
        @(posedge clk); #1;
        reset = 1'b0; rd_ready_i = 1'b1;
        @(negedge clk);
        m0 = mosi_log.size(); g0 = got.size(); c0 = ctrl_log.size(); d0 = done_cnt;
        start_seq(24'h000010, 16'd2, 3'd2, 3'd0);
        wait_done(2000, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_rerun_timeout: done seen=%b want 1", !to); end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (qbyte(mosi_log, m0 + i) !== exp_m[i]) begin n_bad++; $display("FAIL rstmid_mosi[%0d]: got %h want %h", i, qbyte(mosi_log, m0 + i), exp_m[i]); end
        end
        n_cmp++; if (got.size() - g0 != 2) begin n_bad++; $display("FAIL rstmid_rd_count: got %0d want 2", got.size() - g0); end
        n_cmp++; if (qbyte(got, g0) !== 8'hB5)     begin n_bad++; $display("FAIL rstmid_rd0: got %h want b5", qbyte(got, g0)); end
        n_cmp++; if (qbyte(got, g0 + 1) !== 8'hB4) begin n_bad++; $display("FAIL rstmid_rd1: got %h want b4", qbyte(got, g0 + 1)); end
        n_cmp++; if (qbyte(ctrl_log, c0) !== 8'h02) begin n_bad++; $display("FAIL rstmid_ctrl_sel: got %h want 02", qbyte(ctrl_log, c0)); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL rstmid_done_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        reset = 1'b1;
        cpu_d_i = '0; cpu_wr_i = 1'b0; cpu_rd_i = 1'b0; cpu_ad_i = 1'b0;
        start_i = 1'b0; addr_i = '0; len_i = '0; target_i = '0; speed_i = '0;
        rd_ready_i = 1'b1;
        test_reset();
        test_passthrough();
        test_read_len3();
        test_len0();
        test_backpressure();
        test_cpu_blocked();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
